mem_access_wb: RTL and testbench

- MEM stage plus MEM/WB pipeline register of the 5-stage RV32I pipeline.
- Consumes EX/MEM outputs and performs loads/stores over a req/ack data-memory bus with variable latency. Handles byte-lane alignment and load sign-extension.
- Drives the write-back triple (RegWrite, Rd, WriteData) into the decode-stage register file. This is the producing end of the decode write-back/forwarding interface.
- Stalls upstream while a bus access is outstanding.

---
 rtl/rv_pkg.sv | 16 +
 rtl/lsu_align.sv | 78 +++++++
 rtl/mem_access_wb.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_wb.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the MEM stage: funct3 access codes and the
// memory-access FSM state type.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension and
// misalignment detection. Purely combinational.
module lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store lanes: unknown sizes fall back to a full word
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_H: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
      end
    endcase
  end

  // Lane extraction for loads
  always_comb begin
    byte_s = rdata_i[7:0];
    case (off_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    if (off_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
  end

  // Load result formatting
  always_comb begin
    load_o = rdata_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_o = {{16{half_s[15]}}, half_s};
      F3_BU:   load_o = {24'd0, byte_s};
      F3_HU:   load_o = {16'd0, half_s};
      default: load_o = rdata_i;
    endcase
  end

  // Alignment is judged from the size bits only
  always_comb begin
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misalign_o = off_i[0];
      2'b10:   misalign_o = (off_i != 2'b00);
      default: misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_wb.sv
// MEM stage and MEM/WB register: issues loads/stores on a req/ack bus,
// stalls upstream while busy and produces the write-back triple.
module mem_access_wb
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        Ctl_RegWrite_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  Rd_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] StoreData_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        Ctl_RegWrite_out,
  output logic [4:0]  Rd_out,
  output logic [31:0] WriteData_out
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic             TO_EN   = (TIMEOUT_CYCLES != 32'd0);

  mem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, ld_q, ld_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d, rd_out_q, rd_out_d;
  logic        regw_q, regw_d, mis_q, mis_d, berr_q, berr_d;
  logic [31:0] wb_q, wb_d;

  logic        busy_s, access_s, timeout_s;
  logic [2:0]  f3_sel_s;
  logic [1:0]  off_sel_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, load_s;
  logic        misalign_s;

  assign busy_s    = (state_q == BUSY);
  assign access_s  = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign f3_sel_s  = busy_s ? f3_q  : funct3_in;
  assign off_sel_s = busy_s ? off_q : ALUresult_in[1:0];
  assign timeout_s = TO_EN & busy_s & ~dmem_ack & (cnt_q == TO_LAST);

  lsu_align u_align (
    .funct3_i     (f3_sel_s),
    .off_i        (off_sel_s),
    .store_data_i (StoreData_in),
    .rdata_i      (dmem_rdata),
    .be_o         (be_s),
    .wdata_o      (wdata_s),
    .load_o       (load_s),
    .misalign_o   (misalign_s)
  );

  // Timeout cycle releases the stall so the aborted instruction retires
  assign mem_stall = (~busy_s & access_s & ~misalign_s) |
                     (busy_s & ~dmem_ack & ~timeout_s);

  // Next-state and MEM/WB slot; per-cycle outputs default to a bubble
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    ld_d     = ld_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    regw_d   = 1'b0;
    rd_out_d = 5'd0;
    wb_d     = 32'd0;
    mis_d    = 1'b0;
    berr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_s && !misalign_s) begin
          state_d = BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = Ctl_MemWrite_in;
          ld_d    = Ctl_MemRead_in & ~Ctl_MemWrite_in;
          addr_d  = {ALUresult_in[31:2], 2'b00};
          wdata_d = wdata_s;
          be_d    = be_s;
          f3_d    = funct3_in;
          off_d   = ALUresult_in[1:0];
          rd_d    = Rd_in;
        end else if (access_s) begin
          mis_d = 1'b1;
        end else begin
          regw_d   = Ctl_RegWrite_in & (Rd_in != 5'd0);
          rd_out_d = Rd_in;
          wb_d     = ALUresult_in;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          if (ld_q) begin
            regw_d   = (rd_q != 5'd0);
            rd_out_d = rd_q;
            wb_d     = load_s;
          end else begin
            regw_d = 1'b0;
          end
        end else if (timeout_s) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, bus and MEM/WB registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      ld_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      rd_q     <= 5'd0;
      regw_q   <= 1'b0;
      rd_out_q <= 5'd0;
      wb_q     <= 32'd0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      ld_q     <= ld_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      regw_q   <= regw_d;
      rd_out_q <= rd_out_d;
      wb_q     <= wb_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_be          = be_q;
  assign misalign_err     = mis_q;
  assign bus_err          = berr_q;
  assign Ctl_RegWrite_out = regw_q;
  assign Rd_out           = rd_out_q;
  assign WriteData_out    = wb_q;

endmodule

// File: tb/tb_mem_access_wb.sv
// Directed and randomized bench for mem_access_wb against an arithmetic
// reference model of the access rules (timeout set to 8 cycles).
module tb_mem_access_wb;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Ctl_MemRead_in = 1'b0, Ctl_MemWrite_in = 1'b0, Ctl_RegWrite_in = 1'b0;
  logic [2:0]  funct3_in = 3'd0;
  logic [4:0]  Rd_in = 5'd0;
  logic [31:0] ALUresult_in = 32'd0, StoreData_in = 32'd0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
  logic [3:0]  dmem_be;
  logic        mem_stall, misalign_err, bus_err, Ctl_RegWrite_out;
  logic [4:0]  Rd_out;
  logic [31:0] WriteData_out;

  int checks = 0;
  int errors = 0;

  mem_access_wb #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in),
    .Ctl_RegWrite_in(Ctl_RegWrite_in), .funct3_in(funct3_in), .Rd_in(Rd_in),
    .ALUresult_in(ALUresult_in), .StoreData_in(StoreData_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .misalign_err(misalign_err),
    .bus_err(bus_err), .Ctl_RegWrite_out(Ctl_RegWrite_out), .Rd_out(Rd_out),
    .WriteData_out(WriteData_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b01) return (a % 2) != 0;
    if (f3[1:0] == 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input int off);
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] r);
    logic [31:0] b, h;
    b = (r >> (8 * off)) & 32'hFF;
    h = (r >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return r;
    endcase
  endfunction

  task automatic clear_in();
    Ctl_MemRead_in = 1'b0; Ctl_MemWrite_in = 1'b0; Ctl_RegWrite_in = 1'b0;
    funct3_in = 3'd0; Rd_in = 5'd0; ALUresult_in = 32'd0; StoreData_in = 32'd0;
  endtask

  // One instruction through MEM; ack_n = BUSY cycle of the ack, 0 = never
  task automatic run_op(input logic rd_en, input logic wr_en, input logic regw,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input int ack_n);
    logic access, mis, is_load, done, acked;
    int n;
    Ctl_MemRead_in = rd_en; Ctl_MemWrite_in = wr_en; Ctl_RegWrite_in = regw;
    funct3_in = f3; Rd_in = rd; ALUresult_in = addr; StoreData_in = data;
    access  = rd_en | wr_en;
    mis     = access && ref_mis(f3, addr);
    is_load = rd_en && !wr_en;
    #1;
    chk("stall_issue", mem_stall, access && !mis);
    @(posedge CLK); #1;
    if (!access) begin
      chk("alu_regw", Ctl_RegWrite_out, regw && rd != 5'd0);
      chk("alu_rd", Rd_out, rd);
      chk("alu_data", WriteData_out, addr);
      chk("alu_req", dmem_req, 1'b0);
      clear_in();
      return;
    end
    if (mis) begin
      chk("mis_pulse", misalign_err, 1'b1);
      chk("mis_req", dmem_req, 1'b0);
      chk("mis_regw", Ctl_RegWrite_out, 1'b0);
      clear_in();
      @(posedge CLK); #1;
      chk("mis_pulse_end", misalign_err, 1'b0);
      chk("mis_req_after", dmem_req, 1'b0);
      return;
    end
    chk("no_mis", misalign_err, 1'b0);
    done = 1'b0; acked = 1'b0; n = 1;
    while (!done) begin
      chk("busy_req", dmem_req, 1'b1);
      chk("busy_we", dmem_we, wr_en);
      chk("busy_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      chk("busy_bubble", Ctl_RegWrite_out, 1'b0);
      if (wr_en) begin
        chk("busy_be", dmem_be, ref_be(f3, int'(addr[1:0])));
        chk("busy_wdata", dmem_wdata, ref_wdata(f3, data));
      end
      if (n == ack_n) begin
        dmem_ack = 1'b1; dmem_rdata = rdata; acked = 1'b1;
      end else begin
        dmem_rdata = $urandom;
      end
      #1;
      chk("busy_stall", mem_stall, !(n == ack_n || n == TO));
      done = (n == ack_n) || (n == TO);
      @(posedge CLK); #1;
      dmem_ack = 1'b0;
      n++;
    end
    clear_in();
    chk("end_req", dmem_req, 1'b0);
    chk("end_buserr", bus_err, !acked);
    chk("end_regw", Ctl_RegWrite_out, acked && is_load && rd != 5'd0);
    if (acked && is_load && rd != 5'd0) begin
      chk("end_rd", Rd_out, rd);
      chk("end_load", WriteData_out, ref_load(f3, int'(addr[1:0]), rdata));
    end
    if (!acked) begin
      @(posedge CLK); #1;
      chk("buserr_end", bus_err, 1'b0);
    end
  endtask

  initial begin
    logic [2:0] f3_tbl [5];
    int k;
    f3_tbl[0] = 3'd0; f3_tbl[1] = 3'd1; f3_tbl[2] = 3'd2; f3_tbl[3] = 3'd4; f3_tbl[4] = 3'd5;

    #1;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_regw", Ctl_RegWrite_out, 1'b0);
    chk("rst_data", WriteData_out, 32'd0);
    chk("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    run_op(1'b0, 1'b0, 1'b1, 3'd0, 5'd5, 32'h42, 32'd0, 32'd0, 1);
    run_op(1'b0, 1'b0, 1'b1, 3'd0, 5'd0, 32'h42, 32'd0, 32'd0, 1);
    run_op(1'b0, 1'b1, 1'b0, 3'd2, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'd0, 3);
    run_op(1'b0, 1'b1, 1'b0, 3'd1, 5'd0, 32'h102, 32'h0000_ABCD, 32'd0, 1);
    run_op(1'b1, 1'b0, 1'b1, 3'd0, 5'd7, 32'h103, 32'd0, 32'h80FF_1234, 2);
    run_op(1'b1, 1'b0, 1'b1, 3'd4, 5'd8, 32'h103, 32'd0, 32'h80FF_1234, 1);
    run_op(1'b1, 1'b0, 1'b1, 3'd1, 5'd9, 32'h102, 32'd0, 32'h80FF_1234, 1);
    run_op(1'b1, 1'b0, 1'b1, 3'd2, 5'd3, 32'h102, 32'd0, 32'h1234_5678, 1);
    run_op(1'b1, 1'b1, 1'b1, 3'd2, 5'd4, 32'h200, 32'h1111_2222, 32'h3333_4444, 2);
    run_op(1'b1, 1'b0, 1'b1, 3'd2, 5'd6, 32'h300, 32'd0, 32'd0, 0);

    // Reset during BUSY, then a stray ack in IDLE
    Ctl_MemRead_in = 1'b1; Ctl_RegWrite_in = 1'b1; funct3_in = 3'd2;
    Rd_in = 5'd10; ALUresult_in = 32'h400;
    @(posedge CLK); #1;
    chk("pre_rst_req", dmem_req, 1'b1);
    @(posedge CLK); #2;
    clear_in();
    RESET = 1'b1;
    #1;
    chk("midrst_req", dmem_req, 1'b0);
    chk("midrst_stall", mem_stall, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    dmem_ack = 1'b0;
    chk("late_ack_req", dmem_req, 1'b0);
    chk("late_ack_regw", Ctl_RegWrite_out, 1'b0);
    chk("late_ack_data", WriteData_out, 32'd0);
    run_op(1'b0, 1'b0, 1'b1, 3'd0, 5'd12, 32'h1357_9BDF, 32'd0, 32'd0, 1);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 3);
      run_op(k == 1 || k == 3, k == 2 || k == 3, $urandom_range(0, 1) == 1,
             f3_tbl[$urandom_range(0, 4)], 5'($urandom_range(0, 31)),
             ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
             $urandom, $urandom, $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
